// File: rtl/char_fifo_pkg.sv
// Shared constants and state encoding for the character FIFO and its
// optional strobe synchronizer.
package char_fifo_pkg;

  localparam int unsigned CHAR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 100;

  // End-of-message terminator; never stored in the FIFO.
  localparam logic [CHAR_W_DEF-1:0] NUL_CHAR = '0;

  typedef enum logic [1:0] {
    StIdle,
    StFilling,
    StDraining,
    StDone
  } state_e;

endpackage

// File: rtl/char_strobe_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous character
// strobe; emits one registered pulse per edge with the character captured alongside.
module char_strobe_sync #(
  parameter int unsigned CHAR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_strobe,
  input  logic [CHAR_W-1:0] i_char,
  output logic              o_pulse,
  output logic [CHAR_W-1:0] o_char
);

  logic [2:0]        r_sync;
  logic              r_pulse;
  logic [CHAR_W-1:0] r_char;
  logic              w_rise;

  // r_sync[0] may go metastable; only r_sync[1] and later are used.
  assign w_rise = r_sync[1] & ~r_sync[2];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_pulse <= 1'b0;
      r_char  <= '0;
    end else begin
      r_sync  <= {r_sync[1:0], i_strobe};
      r_pulse <= w_rise;
      if (w_rise) begin
        r_char <= i_char;
      end
    end
  end

  assign o_pulse = r_pulse;
  assign o_char  = r_char;

endmodule

// File: rtl/char_fifo.sv
// Parametrised first-word-fall-through character FIFO with NUL end-of-message detection.
// Define CHAR_FIFO_SYNC_STROBE_EN to treat wr_valid as an asynchronous strobe.
module char_fifo
  import char_fifo_pkg::*;
#(
  parameter  int unsigned CHAR_W = CHAR_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [CHAR_W-1:0] rd_char,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              END_OF_BUFFER,
  output logic              overflow
);

  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_nxt;
  logic              r_overflow;
  state_e            r_state;
  state_e            w_state_nxt;

  logic              w_req;
  logic [CHAR_W-1:0] w_req_char;
  logic              w_full;
  logic              w_accepting;
  logic              w_push;
  logic              w_nul;
  logic              w_store;
  logic              w_pop;

`ifdef CHAR_FIFO_SYNC_STROBE_EN
  char_strobe_sync #(
    .CHAR_W (CHAR_W)
  ) u_strobe_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_strobe (wr_valid),
    .i_char   (wr_char),
    .o_pulse  (w_req),
    .o_char   (w_req_char)
  );
`else
  assign w_req      = wr_valid;
  assign w_req_char = wr_char;
`endif

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
    return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
  endfunction

  assign w_full      = (r_count == (ADDR_W + 1)'(DEPTH));
  assign w_accepting = (r_state == StIdle) || (r_state == StFilling);
  assign w_push      = w_req && w_accepting && !w_full;
  assign w_nul       = (w_req_char == CHAR_W'(NUL_CHAR));
  assign w_store     = w_push && !w_nul;
  assign w_pop       = (r_count != '0) && rd_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_store, w_pop})
      2'b10:   w_count_nxt = r_count + (ADDR_W + 1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_W + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a terminator with nothing left after this cycle's pop
  // completes the message immediately.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_push) begin
          w_state_nxt = w_nul ? StDone : StFilling;
        end
      end
      StFilling: begin
        if (w_push && w_nul) begin
          w_state_nxt = (w_count_nxt != '0) ? StDraining : StDone;
        end
      end
      StDraining: begin
        if (w_count_nxt == '0) begin
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Outputs decode registered state only; no path from rd_ready to wr_ready.
  always_comb begin
    wr_ready      = w_accepting && !w_full;
    rd_valid      = (r_count != '0);
    rd_char       = rd_valid ? r_mem[r_rd_ptr] : '0;
    count         = r_count;
    END_OF_BUFFER = (r_state == StDone);
    overflow      = r_overflow;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_nxt;
      if (w_req && w_full && w_accepting) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; rd_char is masked while empty.
  always_ff @(posedge clock) begin
    if (reset_n && !clear && w_store) begin
      r_mem[r_wr_ptr] <= w_req_char;
    end
  end

endmodule

// File: tb/tb_char_fifo.sv
// Self-checking bench for char_fifo: hand-derived vector table plus a queue
// scoreboard driving fill, overflow, wrap, terminator and flush sequences.
module tb_char_fifo;

  localparam int CW = 8;
  localparam int DP = 100;
  localparam int AW = $clog2(DP);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic [CW-1:0] wr_char;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] rd_char;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW:0]   count;
  logic          eob;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] m_q[$];
  bit            m_term;
  bit            m_ovf;

  typedef struct {
    bit           clr;
    bit           vld;
    logic [7:0]   ch;
    bit           rdy;
    int           cnt;
    bit           rdv;
    logic [7:0]   rch;
    bit           wrr;
    bit           eob;
    bit           ovf;
  } vec_t;

  vec_t tbl[10];

  char_fifo #(
    .CHAR_W (CW),
    .DEPTH  (DP)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear         (clear),
    .wr_char       (wr_char),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_char       (rd_char),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .count         (count),
    .END_OF_BUFFER (eob),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int head;
    head = (m_q.size() != 0) ? int'(m_q[0]) : 0;
    chk("count", int'(count), m_q.size());
    chk("rd_valid", int'(rd_valid), int'(m_q.size() != 0));
    chk("rd_char", int'(rd_char), head);
    chk("wr_ready", int'(wr_ready), int'(!m_term && m_q.size() < DP));
    chk("end_of_buffer", int'(eob), int'(m_term && m_q.size() == 0));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  // One clock of stimulus; the scoreboard pops and compares on every consumer pop.
  task automatic cyc(input bit clr, input bit vld, input logic [7:0] ch, input bit rdy);
    bit full;
    bit push;
    bit pop;
    clear    = clr;
    wr_valid = vld;
    wr_char  = ch;
    rd_ready = rdy;
    #1;
    full = (m_q.size() == DP);
    push = vld && !m_term && !full;
    pop  = rdy && (m_q.size() != 0);
    if (reset_n && !clr && pop) begin
      chk("sb_pop_char", int'(rd_char), int'(m_q[0]));
    end
    @(posedge clock);
    #1;
    if (!reset_n || clr) begin
      m_q.delete();
      m_term = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (vld && full && !m_term) m_ovf = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (ch != 8'h00) m_q.push_back(ch);
        else m_term = 1'b1;
      end
    end
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk({tag, "_rd_char"}, int'(rd_char), 0);
    chk({tag, "_wr_ready"}, int'(wr_ready), 1);
    chk({tag, "_eob"}, int'(eob), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  function automatic logic [7:0] gen_char(input int i);
    return 8'(33 + (i % 90));
  endfunction

  initial begin
    //           clr vld  ch     rdy  cnt rdv rch    wrr eob ovf
    tbl[0] = '{1'b0, 1'b1, 8'h48, 1'b0, 1, 1'b1, 8'h48, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h49, 1'b0, 2, 1'b1, 8'h48, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 2, 1'b1, 8'h48, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h49, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h41, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 8'h41, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    reset_n  = 1'b0;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_char  = '0;
    rd_ready = 1'b0;
    m_term   = 1'b0;
    m_ovf    = 1'b0;

`ifdef CHAR_FIFO_SYNC_STROBE_EN
    begin
      int lat;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      check_reset_values("strobe_reset");
      wr_valid = 1'b1;
      wr_char  = 8'h5A;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clock);
        #1;
        if (rd_valid && lat == 0) lat = i;
      end
      wr_valid = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      chk("strobe_latency", lat, 4);
      chk("strobe_count", int'(count), 1);
      chk("strobe_char", int'(rd_char), 'h5A);
      wr_char  = 8'h5B;
      wr_valid = 1'b1;
      repeat (8) @(posedge clock);
      #1;
      chk("strobe_second_count", int'(count), 2);
      chk("strobe_head_kept", int'(rd_char), 'h5A);
    end
`else
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_reset_values("reset");
    reset_n = 1'b1;

    // "HI" + NUL, then drain; empty-message and flush rows follow.
    for (int v = 0; v < 10; v++) begin
      cyc(tbl[v].clr, tbl[v].vld, tbl[v].ch, tbl[v].rdy);
      chk($sformatf("tbl%0d_count", v), int'(count), tbl[v].cnt);
      chk($sformatf("tbl%0d_rd_valid", v), int'(rd_valid), int'(tbl[v].rdv));
      chk($sformatf("tbl%0d_rd_char", v), int'(rd_char), int'(tbl[v].rch));
      chk($sformatf("tbl%0d_wr_ready", v), int'(wr_ready), int'(tbl[v].wrr));
      chk($sformatf("tbl%0d_eob", v), int'(eob), int'(tbl[v].eob));
      chk($sformatf("tbl%0d_overflow", v), int'(overflow), int'(tbl[v].ovf));
    end

    // Fill to DEPTH, then overrun.
    for (int i = 0; i < DP; i++) cyc(1'b0, 1'b1, gen_char(i), 1'b0);
    chk("full_wr_ready", int'(wr_ready), 0);
    cyc(1'b0, 1'b1, 8'h41, 1'b0);
    chk("full_overflow", int'(overflow), 1);
    chk("full_count", int'(count), DP);
    chk("full_head", int'(rd_char), int'(gen_char(0)));
    cyc(1'b0, 1'b1, 8'h42, 1'b1);
    chk("full_pop_no_push", int'(count), DP - 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("overflow_sticky", int'(overflow), 1);

    // Steady push/pop across the pointer wrap.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, gen_char(i), 1'b0);
    for (int i = 30; i < 160; i++) begin
      cyc(1'b0, 1'b1, gen_char(i), 1'b1);
      if (count != 30) chk("wrap_count", int'(count), 30);
    end
    chk("wrap_count_end", int'(count), 30);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("wrap_drained_eob", int'(eob), 1);

    // Clear while draining five characters.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, gen_char(i + 7), 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("draining_count", int'(count), 5);
    chk("draining_wr_ready", int'(wr_ready), 0);
    cyc(1'b1, 1'b1, 8'h41, 1'b1);
    check_reset_values("clear");

    // Reset together with clear.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, gen_char(i + 50), 1'b0);
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 8'h41, 1'b1);
    reset_n = 1'b1;
    check_reset_values("reset_clear");
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    chk("post_reset_push", int'(rd_char), 'h55);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
